ru_wb_arbiter: RTL

- Write-back arbiter/sequencer for the single write port of the register unit (RU) in the RISC-V core.
- Two requesters share the port through valid/ready handshakes, granted round-robin: req0 is ALU/immediate write-back, req1 is load/LSU write-back.
- A registered output stage drives the RU write port (RU_Wr/Rd/RU_Data_Wr).
- Also provides a pending-write bitmap for hazard logic and a saturating commit counter.

---
 rtl/ru_wb_arbiter_if.sv | 53 +++++
 rtl/ru_wb_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/ru_wb_arbiter_if.sv
// ============================================================================
// Module   : ru_wb_arbiter_if
// Purpose  : Bundles the two write-back request channels, the hold control
//            and the register-unit write port driven by ru_wb_arbiter.
// Ports    : req0_*/req1_* valid/rd/data/ready handshakes, wb_hold,
//            RU_Wr/Rd/RU_Data_Wr write port, pending bitmap, commit_count.
//            master = requester/consumer side, slave = the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ru_wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [4:0]       req0_rd;
  logic [XLEN-1:0]  req0_data;
  logic             req0_ready;

  logic             req1_valid;
  logic [4:0]       req1_rd;
  logic [XLEN-1:0]  req1_data;
  logic             req1_ready;

  logic             wb_hold;

  logic             RU_Wr;
  logic [4:0]       Rd;
  logic [XLEN-1:0]  RU_Data_Wr;
  logic [31:0]      pending;
  logic [CNT_W-1:0] commit_count;

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    output wb_hold,
    input  RU_Wr, Rd, RU_Data_Wr, pending, commit_count
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    input  wb_hold,
    output RU_Wr, Rd, RU_Data_Wr, pending, commit_count
  );
endinterface

`default_nettype wire

// File: rtl/ru_wb_arbiter.sv
// ============================================================================
// Module   : ru_wb_arbiter
// Purpose  : Round-robin write-back arbiter for the single RU write port.
//            req0 (ALU/imm) and req1 (LSU) compete through valid/ready; the
//            winner is captured in a one-entry output stage that drives the
//            RU write port. Also exports a pending-write bitmap and a
//            saturating commit counter.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-low reset
//            bus  - ru_wb_arbiter_if.slave (requests, hold, RU write port)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ru_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ru_wb_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  // State
  logic             out_valid_q, out_valid_d;
  logic [4:0]       rd_q,        rd_d;
  logic [XLEN-1:0]  data_q,      data_d;
  logic             last_grant_q, last_grant_d;   // 1 = req1 won last
  logic [CNT_W-1:0] count_q,     count_d;

  // Combinational
  logic             w_grant0;
  logic             w_grant1;
  logic             w_xfer;
  logic [4:0]       w_sel_rd;
  logic [XLEN-1:0]  w_sel_data;
  logic             w_ru_wr;

  always_comb begin
    // With both requesting, the one that did not win last time gets the port.
    w_grant0   = bus.req0_valid & ~bus.wb_hold & (~bus.req1_valid |  last_grant_q);
    w_grant1   = bus.req1_valid & ~bus.wb_hold & (~bus.req0_valid | ~last_grant_q);
    w_xfer     = w_grant0 | w_grant1;
    w_sel_rd   = w_grant1 ? bus.req1_rd   : bus.req0_rd;
    w_sel_data = w_grant1 ? bus.req1_data : bus.req0_data;
    w_ru_wr    = out_valid_q & ~bus.wb_hold;

    out_valid_d  = out_valid_q;
    rd_d         = rd_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;

    if (w_xfer) begin
      last_grant_d = w_grant1;
    end

    // A new non-x0 write replaces the entry even while it retires, giving one
    // write per cycle. Writes to x0 are accepted but never reach the port.
    // A transfer can only happen with wb_hold low, so a loaded entry is
    // never overwritten while frozen.
    if (w_xfer && (w_sel_rd != 5'd0)) begin
      out_valid_d = 1'b1;
      rd_d        = w_sel_rd;
      data_d      = w_sel_data;
    end else if (w_ru_wr) begin
      out_valid_d = 1'b0;
    end

    if (w_ru_wr && (count_q != c_cnt_max)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      rd_q         <= 5'd0;
      data_q       <= '0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
    end
  end

  assign bus.req0_ready   = w_grant0;
  assign bus.req1_ready   = w_grant1;
  assign bus.RU_Wr        = w_ru_wr;
  assign bus.Rd           = rd_q;
  assign bus.RU_Data_Wr   = data_q;
  // rd_q is never 0 while out_valid_q is set; the mask keeps bit 0 clear
  // regardless.
  assign bus.pending      = out_valid_q ? ((32'd1 << rd_q) & ~32'd1) : 32'd0;
  assign bus.commit_count = count_q;

endmodule

`default_nettype wire
